main_fsm: RTL and testbench

Multicycle main controller that sequences the shared datapath (instruction/data memory port, ALU, register file write port, PC) one instruction at a time. It decodes `Op`/`Funct` of the latched instruction and walks a Moore state machine that produces mux selects and raw write enables. The raw `RegW`, `MemW` and `PCS`-related `Branch`/`NextPC` enables feed CONDLOGIC, which gates them by the condition check. It sits beside the ALU decoder in the control unit.

---
 rtl/main_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_main_fsm.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// main_fsm
// Multicycle main controller. Walks one instruction at a time through a
// Moore state machine and produces datapath mux selects plus raw write
// enables (RegW, MemW, Branch, NextPC), which are qualified downstream by the
// condition logic.
//
// Optional build macro: MAINFSM_MEM_WAIT_EN
//   defined   : FETCH, MEMRD and MEMWR hold while MemReady = 0
//   undefined : MemReady is ignored, every state lasts one cycle
//
// Ports
//   clk        clock
//   reset      synchronous active-high reset
//   Op         instruction op field (IR[27:26])
//   Funct      instruction funct field (IR[25:20]); bit 5 = I, bit 0 = L/S
//   MemReady   memory completion (only with MAINFSM_MEM_WAIT_EN)
//   IRWrite    latch instruction register
//   NextPC     PC update request
//   RegW       raw register write
//   MemW       raw memory write
//   Branch     branch state indicator
//   MemReq     memory access active
//   AdrSrc     0 = PC, 1 = ALU result
//   ALUSrcA    0 = RD1, 1 = PC
//   ALUSrcB    0 = RD2, 1 = ExtImm, 2 = constant 4
//   ResultSrc  0 = ALUOut, 1 = Data, 2 = ALUResult
//   ALUOp      1 = ALU decoder uses Funct, 0 = ADD
//   InstrDone  pulse on the last cycle of every instruction
//   Illegal    pulse for Op = 11
//   State      current state code (debug)
//
// state   | meaning
// --------+--------------------------------------------
// FETCH   | read instruction at PC, PC <= PC + 4
// DECODE  | read register file, compute PC + 8
// MEMADR  | compute load/store address
// MEMRD   | read data memory
// MEMWB   | write loaded data to register file
// MEMWR   | write data memory
// EXECR   | ALU op with register operand
// EXECI   | ALU op with immediate operand
// ALUWB   | write ALU result to register file
// BRANCH  | write branch target to PC
// UNKNOWN | illegal op, no side effects
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       MemReq,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       InstrDone,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   mem_ready;

`ifdef MAINFSM_MEM_WAIT_EN
    assign mem_ready = MemReady;
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];
`else
    // Without wait states the memory is assumed to finish every access in
    // one cycle, so MemReady is intentionally left unconnected.
    assign mem_ready = 1'b1;
    logic unused_inputs;
    assign unused_inputs = ^{Funct[4:1], MemReady};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign State = state_q;

    always_comb begin
        state_d   = S_FETCH;
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        MemReq    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'd0;
        ALUSrcB   = 2'd0;
        ResultSrc = 2'd0;
        ALUOp     = 1'b0;
        InstrDone = 1'b0;
        Illegal   = 1'b0;

        case (state_q)
            S_FETCH: begin
                state_d   = mem_ready ? S_DECODE : S_FETCH;
                ALUSrcA   = 2'd1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
                MemReq    = 1'b1;
                // IR and PC only update when the fetch data is really there.
                IRWrite   = mem_ready;
                NextPC    = mem_ready;
            end
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
                ALUSrcA   = 2'd1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
            end
            S_MEMADR: begin
                state_d = Funct[0] ? S_MEMRD : S_MEMWR;
                ALUSrcB = 2'd1;
            end
            S_MEMRD: begin
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
                AdrSrc  = 1'b1;
                MemReq  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'd1;
                RegW      = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWR: begin
                state_d   = mem_ready ? S_FETCH : S_MEMWR;
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
                MemReq    = 1'b1;
                InstrDone = mem_ready;
            end
            S_EXECR: begin
                state_d = S_ALUWB;
                ALUOp   = 1'b1;
            end
            S_EXECI: begin
                state_d = S_ALUWB;
                ALUSrcB = 2'd1;
                ALUOp   = 1'b1;
            end
            S_ALUWB: begin
                RegW      = 1'b1;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'd1;
                ResultSrc = 2'd2;
                Branch    = 1'b1;
                InstrDone = 1'b1;
            end
            S_UNKNOWN: begin
                Illegal   = 1'b1;
                InstrDone = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset kills every side effect in the current cycle and parks the
        // selects on their FETCH values so the datapath sees a quiet PC path.
        if (reset) begin
            IRWrite   = 1'b0;
            NextPC    = 1'b0;
            RegW      = 1'b0;
            MemW      = 1'b0;
            Branch    = 1'b0;
            MemReq    = 1'b0;
            InstrDone = 1'b0;
            Illegal   = 1'b0;
            AdrSrc    = 1'b0;
            ALUSrcA   = 2'd1;
            ALUSrcB   = 2'd2;
            ResultSrc = 2'd2;
            ALUOp     = 1'b0;
        end
    end

endmodule

// File: tb/tb_main_fsm.sv
module tb_main_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite, NextPC, RegW, MemW, Branch, MemReq, AdrSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic       ALUOp, InstrDone, Illegal;
    logic [3:0] State;

`ifdef MAINFSM_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    int n_total = 0;
    int n_bad   = 0;
    bit ready_q[$];

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .MemReady  (MemReady),
        .IRWrite   (IRWrite),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .MemReq    (MemReq),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .InstrDone (InstrDone),
        .Illegal   (Illegal),
        .State     (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {IRWrite, NextPC, RegW, MemW, Branch, MemReq, AdrSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ALUOp, InstrDone, Illegal};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output table of the controller, one row per named step of an instruction.
    function automatic logic [15:0] exp_out(input int st, input bit rdy, input bit rst);
        logic       irw, npc, rw, mw, br, mrq, adr, aop, dn, ill;
        logic [1:0] sa, sb, rs;
        {irw, npc, rw, mw, br, mrq, adr, aop, dn, ill} = '0;
        sa = 2'd0; sb = 2'd0; rs = 2'd0;
        if (rst) begin
            sa = 2'd1; sb = 2'd2; rs = 2'd2;
        end else begin
            case (st)
                0: begin sa = 2'd1; sb = 2'd2; rs = 2'd2; mrq = 1'b1;
                         irw = WAIT_EN ? rdy : 1'b1; npc = irw; end
                1: begin sa = 2'd1; sb = 2'd2; rs = 2'd2; end
                2: sb = 2'd1;
                3: begin adr = 1'b1; mrq = 1'b1; end
                4: begin rs = 2'd1; rw = 1'b1; dn = 1'b1; end
                5: begin adr = 1'b1; mw = 1'b1; mrq = 1'b1;
                         dn = WAIT_EN ? rdy : 1'b1; end
                6: aop = 1'b1;
                7: begin sb = 2'd1; aop = 1'b1; end
                8: begin rw = 1'b1; dn = 1'b1; end
                9: begin sb = 2'd1; rs = 2'd2; br = 1'b1; dn = 1'b1; end
                10: begin ill = 1'b1; dn = 1'b1; end
                default: ;
            endcase
        end
        return {irw, npc, rw, mw, br, mrq, adr, sa, sb, rs, aop, dn, ill};
    endfunction

    // Runs one instruction from FETCH to its last cycle, checking every cycle.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn);
        int q[$];
        int base;
        int cycles = 0;
        int waits  = 0;
        int dones  = 0;
        int regws  = 0;
        int exp_regw;
        bit rdy;
        if (op == 2'b00) begin
            if (fn[5]) q = '{0, 1, 7, 8}; else q = '{0, 1, 6, 8};
            base = 4; exp_regw = 1;
        end else if (op == 2'b01) begin
            if (fn[0]) begin q = '{0, 1, 2, 3, 4}; base = 5; exp_regw = 1; end
            else begin q = '{0, 1, 2, 5}; base = 4; exp_regw = 0; end
        end else if (op == 2'b10) begin
            q = '{0, 1, 9}; base = 3; exp_regw = 0;
        end else begin
            q = '{0, 1, 10}; base = 3; exp_regw = 0;
        end
        Op = op;
        Funct = fn;
        while (q.size() > 0) begin
            @(negedge clk);
            reset = 1'b0;
            if (ready_q.size() > 0) rdy = ready_q.pop_front();
            else rdy = ($urandom_range(0, 3) != 0);
            MemReady = rdy;
            #1;
            check_val("state", State, q[0]);
            check_val("outs", obs, exp_out(q[0], rdy, 1'b0));
            dones += int'(InstrDone);
            regws += int'(RegW);
            if (WAIT_EN && (q[0] == 0 || q[0] == 3 || q[0] == 5) && !rdy) waits++;
            else void'(q.pop_front());
            cycles++;
            if (cycles > 64) begin
                check_val("cycle_budget", cycles, 64);
                break;
            end
        end
        check_val("cycles", cycles, base + waits);
        check_val("instr_done", dones, 1);
        check_val("regw_count", regws, exp_regw);
    endtask

    // LDR aborted by reset while in MEMRD; leaves reset asserted.
    task automatic reset_in_memrd();
        int regws = 0;
        Op = 2'b01;
        Funct = 6'b000001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset = 1'b0;
            MemReady = 1'b1;
            #1;
            check_val("abort_state", State, i);
            check_val("abort_outs", obs, exp_out(i, 1'b1, 1'b0));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("abort_memrd_state", State, 3);
        check_val("abort_memrd_outs", obs, exp_out(3, 1'b1, 1'b1));
        regws += int'(RegW);
        @(negedge clk);
        #1;
        check_val("abort_fetch_state", State, 0);
        check_val("abort_fetch_outs", obs, exp_out(0, 1'b1, 1'b1));
        regws += int'(RegW);
        check_val("abort_regw", regws, 0);
    endtask

    initial begin
        reset = 1'b1;
        Op = 2'b00;
        Funct = 6'b000000;
        MemReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_val("reset_state", State, 0);
            check_val("reset_outs", obs, exp_out(0, 1'b1, 1'b1));
        end

        run_instr(2'b00, 6'b000000);
        run_instr(2'b01, 6'b000001);
        run_instr(2'b01, 6'b000000);
        run_instr(2'b10, 6'b101010);
        run_instr(2'b11, 6'b000000);

        // Slow fetch then a store whose write waits two cycles.
        ready_q = '{0, 0, 0, 1};
        run_instr(2'b00, 6'b100000);
        ready_q = '{1, 1, 1, 0, 0, 1};
        run_instr(2'b01, 6'b000000);

        for (int i = 0; i < 200; i++) begin
            run_instr(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
        end

        reset_in_memrd();
        run_instr(2'b01, 6'b000001);
        run_instr(2'b00, 6'b100001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
